ltl_report_collector: RTL and testbench

LTL_REPORT_COLLECTOR -- requirements
Module: ltl_report_collector

---
 rtl/ltl_report_pkg.sv | 13 +
 rtl/ltl_report_collector_fifo.sv | 60 ++++++
 rtl/ltl_report_collector.sv | 97 +++++++++
 tb/tb_ltl_report_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ltl_report_pkg.sv
// Shared defaults and the report-entry layout for the LTL report collector.
package ltl_report_pkg;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_STAMP_W = 32;
    localparam int DEF_CNT_W   = 16;

    typedef struct packed {
        logic [DEF_STAMP_W-1:0] stamp;
        logic [1:0]             hits;
    } report_entry_t;

endpackage

// File: rtl/ltl_report_collector_fifo.sv
// Report FIFO: power-of-two circular buffer, registered head, push accepted when full if a pop frees a slot.
module report_fifo
    import ltl_report_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = report_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps property reports from the automata cluster, queues them, and keeps hit/drop statistics.
module ltl_report_collector
    import ltl_report_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int STAMP_W = DEF_STAMP_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               ltl0c0,
    input  logic               ltl1c0,
    input  logic               clear_overflow,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [STAMP_W-1:0] rpt_stamp,
    output logic [1:0]         rpt_hits,
    output logic [CNT_W-1:0]   hit_count0,
    output logic [CNT_W-1:0]   hit_count1,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow
);

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [1:0]         hits;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [STAMP_W-1:0] sym_idx;
    logic               push_ev;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    entry_t             push_entry;
    entry_t             head;

    assign push_ev          = run && (ltl0c0 || ltl1c0);
    assign push_entry.stamp = sym_idx;
    assign push_entry.hits  = {ltl1c0, ltl0c0};
    assign pop              = rpt_valid && rpt_ready;
    assign drop             = push_ev && full && !pop;

    report_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ev),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Head is masked while empty so the unreset storage never leaks out.
    assign rpt_valid = !empty;
    assign rpt_stamp = rpt_valid ? head.stamp : '0;
    assign rpt_hits  = rpt_valid ? head.hits  : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_idx    <= '0;
            hit_count0 <= '0;
            hit_count1 <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (run) begin
                sym_idx <= sym_idx + STAMP_W'(1);
            end
            if (run && ltl0c0) begin
                hit_count0 <= sat_inc(hit_count0);
            end
            if (run && ltl1c0) begin
                hit_count1 <= sat_inc(hit_count1);
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
            // A fresh drop wins over a concurrent clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomized and directed bench for ltl_report_collector against a queue-based reference model.
module tb_ltl_report_collector;

    localparam int DEPTH   = 8;
    localparam int STAMP_W = 4;
    localparam int CNT_W   = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int SMOD    = 1 << STAMP_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               run = 1'b0;
    logic               ltl0c0 = 1'b0;
    logic               ltl1c0 = 1'b0;
    logic               clear_overflow = 1'b0;
    logic               rpt_ready = 1'b0;
    logic               rpt_valid;
    logic [STAMP_W-1:0] rpt_stamp;
    logic [1:0]         rpt_hits;
    logic [CNT_W-1:0]   hit_count0;
    logic [CNT_W-1:0]   hit_count1;
    logic [CNT_W-1:0]   drop_count;
    logic               overflow;

    ltl_report_collector #(
        .DEPTH   (DEPTH),
        .STAMP_W (STAMP_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .ltl0c0         (ltl0c0),
        .ltl1c0         (ltl1c0),
        .clear_overflow (clear_overflow),
        .rpt_valid      (rpt_valid),
        .rpt_ready      (rpt_ready),
        .rpt_stamp      (rpt_stamp),
        .rpt_hits       (rpt_hits),
        .hit_count0     (hit_count0),
        .hit_count1     (hit_count1),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {stamp, hits} plus plain integer statistics.
    typedef struct {
        int stamp;
        int hits;
    } m_entry_t;

    m_entry_t q[$];
    int m_sym = 0;
    int m_h0 = 0;
    int m_h1 = 0;
    int m_dc = 0;
    int m_ov = 0;

    always @(posedge clk) begin
        bit m_pop;
        bit m_drop;
        m_entry_t e;
        if (reset) begin
            q.delete();
            m_sym = 0;
            m_h0 = 0;
            m_h1 = 0;
            m_dc = 0;
            m_ov = 0;
        end else begin
            m_pop  = (q.size() > 0) && rpt_ready;
            m_drop = 1'b0;
            if (m_pop) void'(q.pop_front());
            if (run && (ltl0c0 || ltl1c0)) begin
                e.stamp = m_sym;
                e.hits  = {30'd0, ltl1c0, ltl0c0};
                if (q.size() < DEPTH) q.push_back(e);
                else m_drop = 1'b1;
                if (ltl0c0 && m_h0 < CMAX) m_h0++;
                if (ltl1c0 && m_h1 < CMAX) m_h1++;
            end
            if (m_drop) begin
                if (m_dc < CMAX) m_dc++;
                m_ov = 1;
            end else if (clear_overflow) begin
                m_ov = 0;
            end
            if (run) m_sym = (m_sym + 1) % SMOD;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("rpt_valid",  int'(rpt_valid),  (q.size() > 0) ? 1 : 0);
            chk("rpt_stamp",  int'(rpt_stamp),  (q.size() > 0) ? q[0].stamp : 0);
            chk("rpt_hits",   int'(rpt_hits),   (q.size() > 0) ? q[0].hits : 0);
            chk("hit_count0", int'(hit_count0), m_h0);
            chk("hit_count1", int'(hit_count1), m_h1);
            chk("drop_count", int'(drop_count), m_dc);
            chk("overflow",   int'(overflow),   m_ov);
        end
    end

    task automatic tick(input bit rst, input bit r, input bit l0, input bit l1,
                        input bit rdy, input bit clr);
        reset          = rst;
        run            = r;
        ltl0c0         = l0;
        ltl1c0         = l1;
        rpt_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        checking = 1'b1;
        chk("lit_reset_valid", int'(rpt_valid), 0);
        chk("lit_reset_stamp", int'(rpt_stamp), 0);

        // Single report on the third run cycle.
        for (int i = 0; i < 5; i++) tick(0, 1, (i == 2), 0, 0, 0);
        chk("lit_first_stamp", int'(rpt_stamp), 2);
        chk("lit_first_hits",  int'(rpt_hits), 1);
        chk("lit_first_hc0",   int'(hit_count0), 1);

        // Both properties report at index 7.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 1, (i == 7), (i == 7), 0, 0);
        chk("lit_both_stamp", int'(rpt_stamp), 7);
        chk("lit_both_hits",  int'(rpt_hits), 3);
        chk("lit_both_hc1",   int'(hit_count1), 1);

        // Overflow: ten reports into an eight-entry queue.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 1, 0, 0, 0);
        chk("lit_ovf_drops", int'(drop_count), 2);
        chk("lit_ovf_flag",  int'(overflow), 1);
        chk("lit_ovf_head",  int'(rpt_stamp), 0);
        tick(0, 0, 0, 0, 0, 1);
        chk("lit_clr_flag",  int'(overflow), 0);
        chk("lit_clr_drops", int'(drop_count), 2);

        // Push and pop together while full.
        tick(0, 1, 1, 0, 1, 0);
        chk("lit_fullpp_head",  int'(rpt_stamp), 1);
        chk("lit_fullpp_drops", int'(drop_count), 2);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 1, 0);
        chk("lit_drained", int'(rpt_valid), 0);

        // Reports without run are ignored.
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0, 0);
        chk("lit_norun_hc0", int'(hit_count0), 11);
        chk("lit_norun_valid", int'(rpt_valid), 0);

        // Stamp wraps after 2^STAMP_W symbols.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(0, 1, (i == 16), 0, 0, 0);
        chk("lit_wrap_valid", int'(rpt_valid), 1);
        chk("lit_wrap_stamp", int'(rpt_stamp), 0);

        // Reset overrides queued entries and a concurrent push/pop.
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0, 0);
        tick(1, 1, 1, 1, 1, 0);
        chk("lit_rst_valid", int'(rpt_valid), 0);
        chk("lit_rst_hc0",   int'(hit_count0), 0);
        chk("lit_rst_drops", int'(drop_count), 0);

        // Random traffic, with saturating counters exercised by the long run.
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 2 : 7)),
                 ($urandom_range(0, 15) == 0));
        end
        tick(0, 0, 0, 0, 0, 0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
